// File: rtl/edge_evt_pkg.sv
// edge_evt_pkg: shared edge-mode and arbiter-state types for the edge event arbiter
package edge_evt_pkg;
  typedef enum logic [1:0] {
    EDGE_OFF  = 2'b00,
    EDGE_RISE = 2'b01,
    EDGE_FALL = 2'b10,
    EDGE_BOTH = 2'b11
  } edge_mode_t;
  typedef enum logic {
    IDLE  = 1'b0,
    OFFER = 1'b1
  } arb_state_t;
endpackage

// File: rtl/edge_chan_detect.sv
// edge_chan_detect: per-channel mode-qualified rise/fall pulse generator with post-reset arming
module edge_chan_detect
  import edge_evt_pkg::*;
(
  input  logic       clk,
  input  logic       rst,
  input  logic       sig,
  input  logic [1:0] mode,
  output logic       rise,
  output logic       fall
);
  edge_mode_t m;
  logic prev, armed;
  assign m = edge_mode_t'(mode);
  // armed stays low for one cycle after reset so prev can capture the live level first
  always_ff @(posedge clk) begin
    if (rst) begin
      prev  <= 1'b0;
      armed <= 1'b0;
    end else begin
      prev  <= sig;
      armed <= 1'b1;
    end
  end
  assign rise = armed & ~prev & sig & (m == EDGE_RISE || m == EDGE_BOTH);
  assign fall = armed & prev & ~sig & (m == EDGE_FALL || m == EDGE_BOTH);
endmodule

// File: rtl/edge_event_arbiter.sv
// edge_event_arbiter: per-channel edge detection, pending/overflow tracking, round-robin event offer
module edge_event_arbiter
  import edge_evt_pkg::*;
#(
  parameter int NCH = 4,
  parameter int IDW = $clog2(NCH)
) (
  input  logic             clk_i,
  input  logic             rst_i,
  input  logic [NCH-1:0]   sig_i,
  input  logic [2*NCH-1:0] mode_i,
  output logic             evt_valid_o,
  input  logic             evt_ready_i,
  output logic [IDW-1:0]   evt_id_o,
  output logic             evt_rise_o,
  output logic [NCH-1:0]   pend_o,
  output logic [NCH-1:0]   ovf_o,
  input  logic             ovf_clr_i
);
  logic [NCH-1:0] rise, fall, hit, typ, gnt;
  logic [IDW:0]   sel;
  logic [IDW-1:0] ptr;
  arb_state_t     state;

  // returns {found, index}; descending scan makes the smallest offset from ptr win
  function automatic logic [IDW:0] pick(input logic [NCH-1:0] p, input logic [IDW-1:0] from);
    pick = '0;
    for (int i = NCH; i >= 1; i--) begin
      int j;
      j = (int'(from) + i) % NCH;
      if (p[IDW'(j)]) pick = {1'b1, IDW'(j)};
    end
  endfunction

  for (genvar g = 0; g < NCH; g++) begin : g_ch
    edge_chan_detect u_det (
      .clk (clk_i),
      .rst (rst_i),
      .sig (sig_i[g]),
      .mode(mode_i[2*g+:2]),
      .rise(rise[g]),
      .fall(fall[g])
    );
  end

  assign hit = rise | fall;
  assign sel = pick(pend_o, ptr);
  assign gnt = (state == IDLE && sel[IDW]) ? {{(NCH-1){1'b0}}, 1'b1} << sel[IDW-1:0] : '0;

  // a new edge beats a same-cycle grant clear, and a bit cleared by that grant cannot overflow
  always_ff @(posedge clk_i) begin
    if (rst_i) begin
      pend_o <= '0;
      typ    <= '0;
      ovf_o  <= '0;
    end else begin
      pend_o <= (pend_o & ~gnt) | hit;
      typ    <= (typ & ~hit) | rise;
      ovf_o  <= (ovf_o & ~{NCH{ovf_clr_i}}) | (hit & pend_o & ~gnt);
    end
  end

  always_ff @(posedge clk_i) begin
    if (rst_i) begin
      state       <= IDLE;
      evt_valid_o <= 1'b0;
      evt_id_o    <= '0;
      evt_rise_o  <= 1'b0;
      ptr         <= IDW'(NCH - 1);
    end else if (state == IDLE) begin
      if (sel[IDW]) begin
        state       <= OFFER;
        evt_valid_o <= 1'b1;
        evt_id_o    <= sel[IDW-1:0];
        evt_rise_o  <= typ[sel[IDW-1:0]];
        ptr         <= sel[IDW-1:0];
      end
    end else if (evt_ready_i) begin
      state       <= IDLE;
      evt_valid_o <= 1'b0;
    end
  end
endmodule

// File: tb/tb_edge_event_arbiter.sv
// tb_edge_event_arbiter: table-driven and directed checks of the edge event arbiter
module tb_edge_event_arbiter;
  logic       clk = 1'b0;
  logic       rst = 1'b1;
  logic [3:0] sig = 4'b0001;
  logic [7:0] mode = 8'h01;
  logic       ready = 1'b0;
  logic       clr = 1'b0;
  logic       valid, rise_o;
  logic [1:0] id;
  logic [3:0] pend, ovf;
  int errors = 0;
  int checks = 0;

  typedef struct packed {
    logic [3:0] sig;
    logic [7:0] mode;
    logic       ready;
    logic       clr;
    logic       valid;
    logic [1:0] id;
    logic       rise;
    logic [3:0] pend;
    logic [3:0] ovf;
  } vec_t;
  vec_t vecs [17];

  edge_event_arbiter dut (
    .clk_i(clk), .rst_i(rst), .sig_i(sig), .mode_i(mode),
    .evt_valid_o(valid), .evt_ready_i(ready), .evt_id_o(id), .evt_rise_o(rise_o),
    .pend_o(pend), .ovf_o(ovf), .ovf_clr_i(clr)
  );

  always #5 clk = ~clk;

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %0h expected %0h", name, act, exp);
    end
  endtask

  task automatic chk_all(input string tag, input logic v, input logic [1:0] i, input logic r,
                         input logic [3:0] p, input logic [3:0] o);
    chk({tag, " valid"}, 32'(valid), 32'(v));
    chk({tag, " id"}, 32'(id), 32'(i));
    chk({tag, " rise"}, 32'(rise_o), 32'(r));
    chk({tag, " pend"}, 32'(pend), 32'(p));
    chk({tag, " ovf"}, 32'(ovf), 32'(o));
  endtask

  initial begin
    vecs[0]  = '{4'b0001, 8'h01, 1'b0, 1'b0, 1'b0, 2'd0, 1'b0, 4'b0000, 4'b0000};
    vecs[1]  = '{4'b0001, 8'h01, 1'b0, 1'b0, 1'b0, 2'd0, 1'b0, 4'b0000, 4'b0000};
    vecs[2]  = '{4'b0001, 8'h02, 1'b0, 1'b0, 1'b0, 2'd0, 1'b0, 4'b0000, 4'b0000};
    vecs[3]  = '{4'b0000, 8'h02, 1'b0, 1'b0, 1'b0, 2'd0, 1'b0, 4'b0001, 4'b0000};
    vecs[4]  = '{4'b0000, 8'h02, 1'b0, 1'b0, 1'b1, 2'd0, 1'b0, 4'b0000, 4'b0000};
    vecs[5]  = '{4'b0000, 8'h02, 1'b1, 1'b0, 1'b0, 2'd0, 1'b0, 4'b0000, 4'b0000};
    vecs[6]  = '{4'b0000, 8'h55, 1'b1, 1'b0, 1'b0, 2'd0, 1'b0, 4'b0000, 4'b0000};
    vecs[7]  = '{4'b1010, 8'h55, 1'b1, 1'b0, 1'b0, 2'd0, 1'b0, 4'b1010, 4'b0000};
    vecs[8]  = '{4'b1010, 8'h55, 1'b1, 1'b0, 1'b1, 2'd1, 1'b1, 4'b1000, 4'b0000};
    vecs[9]  = '{4'b1010, 8'h55, 1'b1, 1'b0, 1'b0, 2'd1, 1'b1, 4'b1000, 4'b0000};
    vecs[10] = '{4'b1010, 8'h55, 1'b1, 1'b0, 1'b1, 2'd3, 1'b1, 4'b0000, 4'b0000};
    vecs[11] = '{4'b0000, 8'h55, 1'b1, 1'b0, 1'b0, 2'd3, 1'b1, 4'b0000, 4'b0000};
    vecs[12] = '{4'b0011, 8'h55, 1'b1, 1'b0, 1'b0, 2'd3, 1'b1, 4'b0011, 4'b0000};
    vecs[13] = '{4'b0011, 8'h55, 1'b1, 1'b0, 1'b1, 2'd0, 1'b1, 4'b0010, 4'b0000};
    vecs[14] = '{4'b0011, 8'h55, 1'b1, 1'b0, 1'b0, 2'd0, 1'b1, 4'b0010, 4'b0000};
    vecs[15] = '{4'b0011, 8'h55, 1'b1, 1'b0, 1'b1, 2'd1, 1'b1, 4'b0000, 4'b0000};
    vecs[16] = '{4'b0011, 8'h55, 1'b1, 1'b0, 1'b0, 2'd1, 1'b1, 4'b0000, 4'b0000};

    tick();
    tick();
    chk_all("reset", 1'b0, 2'd0, 1'b0, 4'b0000, 4'b0000);
    rst = 1'b0;

    // arming, fall on ch0, simultaneous edges and round-robin order
    for (int i = 0; i < 17; i++) begin
      sig = vecs[i].sig; mode = vecs[i].mode; ready = vecs[i].ready; clr = vecs[i].clr;
      tick();
      chk_all($sformatf("vec%0d", i), vecs[i].valid, vecs[i].id, vecs[i].rise, vecs[i].pend, vecs[i].ovf);
    end

    // backpressure on ch2
    ready = 1'b0; sig = 4'b0111;
    tick(); chk_all("bp edge", 1'b0, 2'd1, 1'b1, 4'b0100, 4'b0000);
    tick(); chk_all("bp offer", 1'b1, 2'd2, 1'b1, 4'b0000, 4'b0000);
    for (int i = 0; i < 4; i++) begin
      tick(); chk_all($sformatf("bp hold%0d", i), 1'b1, 2'd2, 1'b1, 4'b0000, 4'b0000);
    end
    ready = 1'b1;
    tick(); chk_all("bp accept", 1'b0, 2'd2, 1'b1, 4'b0000, 4'b0000);

    // overflow on ch2 while ch0 is stalled in offer
    ready = 1'b0; mode = 8'h77; sig = 4'b0110;
    tick(); chk_all("ov ch0 edge", 1'b0, 2'd2, 1'b1, 4'b0001, 4'b0000);
    tick(); chk_all("ov ch0 offer", 1'b1, 2'd0, 1'b0, 4'b0000, 4'b0000);
    sig = 4'b0010;
    tick(); chk_all("ov first", 1'b1, 2'd0, 1'b0, 4'b0100, 4'b0000);
    sig = 4'b0110;
    tick(); chk_all("ov second", 1'b1, 2'd0, 1'b0, 4'b0100, 4'b0100);
    ready = 1'b1;
    tick(); chk_all("ov accept0", 1'b0, 2'd0, 1'b0, 4'b0100, 4'b0100);
    ready = 1'b0;
    tick(); chk_all("ov newest", 1'b1, 2'd2, 1'b1, 4'b0000, 4'b0100);
    clr = 1'b1;
    tick(); chk_all("ov clear", 1'b1, 2'd2, 1'b1, 4'b0000, 4'b0000);
    clr = 1'b0; sig = 4'b0010;
    tick(); chk_all("ov repend", 1'b1, 2'd2, 1'b1, 4'b0100, 4'b0000);
    clr = 1'b1; sig = 4'b0110;
    tick(); chk_all("ov clr+set", 1'b1, 2'd2, 1'b1, 4'b0100, 4'b0100);
    clr = 1'b0; ready = 1'b1;
    tick(); chk_all("ov drain0", 1'b0, 2'd2, 1'b1, 4'b0100, 4'b0100);
    tick(); chk_all("ov drain1", 1'b1, 2'd2, 1'b1, 4'b0000, 4'b0100);
    tick(); chk_all("ov drain2", 1'b0, 2'd2, 1'b1, 4'b0000, 4'b0100);

    // mode 00 masking on ch1
    mode = 8'h73;
    sig = 4'b0100; tick(); chk("mask t0 pend", 32'(pend), 32'(4'b0000));
    sig = 4'b0110; tick(); chk("mask t1 pend", 32'(pend), 32'(4'b0000));
    sig = 4'b0100; tick(); chk("mask t2 pend", 32'(pend), 32'(4'b0000));
    chk("mask valid", 32'(valid), 32'(0));
    mode = 8'h77; ready = 1'b0; sig = 4'b0101;
    tick(); chk_all("mask ch0 edge", 1'b0, 2'd2, 1'b1, 4'b0001, 4'b0100);
    tick(); chk_all("mask ch0 offer", 1'b1, 2'd0, 1'b1, 4'b0000, 4'b0100);
    sig = 4'b0111;
    tick(); chk_all("mask ch1 pend", 1'b1, 2'd0, 1'b1, 4'b0010, 4'b0100);
    mode = 8'h73; sig = 4'b0101;
    tick(); chk_all("mask keep", 1'b1, 2'd0, 1'b1, 4'b0010, 4'b0100);
    ready = 1'b1;
    tick(); chk_all("mask acc0", 1'b0, 2'd0, 1'b1, 4'b0010, 4'b0100);
    tick(); chk_all("mask deliver", 1'b1, 2'd1, 1'b1, 4'b0000, 4'b0100);
    tick(); chk_all("mask acc1", 1'b0, 2'd1, 1'b1, 4'b0000, 4'b0100);

    // reset during offer drops the event and pending state
    ready = 1'b0; sig = 4'b0100;
    tick(); chk_all("rst pend", 1'b0, 2'd1, 1'b1, 4'b0001, 4'b0100);
    tick(); chk_all("rst offer", 1'b1, 2'd0, 1'b0, 4'b0000, 4'b0100);
    sig = 4'b0000;
    tick(); chk_all("rst extra", 1'b1, 2'd0, 1'b0, 4'b0100, 4'b0100);
    rst = 1'b1;
    tick(); chk_all("rst mid", 1'b0, 2'd0, 1'b0, 4'b0000, 4'b0000);
    rst = 1'b0; ready = 1'b1;
    for (int i = 0; i < 6; i++) begin
      tick(); chk_all($sformatf("post rst%0d", i), 1'b0, 2'd0, 1'b0, 4'b0000, 4'b0000);
    end

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end
endmodule

// File: doc/edge_event_arbiter.md
# edge_event_arbiter

Multi-channel edge-event controller that owns a bank of per-channel edge detectors and shares a single event output port between them. Each channel turns a configured edge (rising, falling or both) on its input into a pending request; a round-robin arbiter grants one pending channel at a time onto a valid/ready event stream consumed by the interrupt/status logic. Events that arrive while a channel is already pending are counted as overflow in sticky flags.

## Interface
- NCH, 4, number of input channels (2..16)
- IDW, $clog2(NCH), width of channel index
- clk_i  input  1  clock, all logic rising-edge
- rst_i  input  1  reset, synchronous, active-high
- sig_i  input  NCH  monitored signals, already synchronous to clk_i
- mode_i  input  2*NCH  per-channel edge mode, channel k at [2k+1:2k]: 00 off, 01 rising, 10 falling, 11 both
- evt_valid_o  output  1  event offered
- evt_ready_i  input  1  consumer accepts event
- evt_id_o  output  IDW  channel index of offered event
- evt_rise_o  output  1  1 = rising edge, 0 = falling edge
- pend_o  output  NCH  pending flags
- ovf_o  output  NCH  sticky overflow flags
- ovf_clr_i  input  1  clears all overflow flags

## Operation
- Reset values: evt_valid_o 0, evt_id_o 0, evt_rise_o 0, pend_o 0, ovf_o 0; previous-sample regs 0; RR pointer NCH-1 (channel 0 has first priority); FSM IDLE.
- Arm: detection is suppressed in the first cycle after rst_i deasserts (previous-sample regs load sig_i); no spurious edge from a signal already high.
- Detection per channel: rise = ~prev & sig, fall = prev & ~sig, qualified by mode_i. Mode 00 masks detection only; an already-set pending flag is kept.
- Pending: a qualified edge sets pend[k] and records its type (rise/fall) in a per-channel type bit. If pend[k] already set, type is overwritten with the newest edge and ovf[k] sets.
- FSM IDLE: if any pend set, choose first pending channel searching from pointer+1 with wrap to 0; load evt_id_o/evt_rise_o, clear that pend bit, update pointer to granted index, assert evt_valid_o, go OFFER.
- FSM OFFER: outputs held stable while evt_valid_o & ~evt_ready_i. On evt_valid_o & evt_ready_i: deassert evt_valid_o, go IDLE.
- Edge on granted channel during OFFER re-sets its pend bit (no overflow, since pend was cleared at grant).
- Simultaneous set and clear of a pend bit (IDLE grant in same cycle as new edge on same channel): set wins, no overflow.
- ovf_clr_i and a new overflow in the same cycle: set wins.
- rst_i asserted mid-offer: all state cleared next edge; offered event is dropped.

## Timing
- Edge sampled on sig_i in cycle t: pend_o high in t+1; evt_valid_o high in t+2 if FSM idle (arbitration latency 1 cycle).
- Handshake in cycle h: evt_valid_o low in h+1; next event offered earliest in h+2 (one bubble cycle, fixed).
- Maximum throughput one event per 2 cycles; sustained edges faster than NCH*2 cycles per channel overflow.
- evt_id_o/evt_rise_o change only when evt_valid_o rises.
- All outputs registered; no combinational path input-to-output.

## Structure
- Package edge_evt_pkg: edge_mode_t enum (EDGE_OFF, EDGE_RISE, EDGE_FALL, EDGE_BOTH), arb_state_t enum (IDLE, OFFER).
- Sub-module edge_chan_detect: one per channel via generate; holds previous-sample reg and arm gating, takes mode, outputs one-cycle rise/fall pulses; synchronous active-high reset.
- Top holds pend/type/ovf regs, RR pointer, FSM and output regs.

## Test plan
- Reset then sig_i[0] held high, mode 01: no event; then 1->0 with mode 10 -> evt_valid_o at t+2, evt_id_o 0, evt_rise_o 0.
- Rising edges on channels 1 and 3 in same cycle, ready tied high: events id 1 then id 3, valid pulses 2 cycles apart; next simultaneous edges on 0 and 1 -> order 0, 1 after pointer at 3.
- Backpressure: ready low 5 cycles with event on id 2 -> outputs stable, valid held; accept on cycle 6 -> valid low next cycle.
- Two edges on channel 2 while pending (mode 11) -> ovf_o[2] = 1, evt_rise_o reports newest edge; ovf_clr_i pulse -> ovf_o 0; clear coincident with new overflow -> stays 1.
- Mode 00 on channel 1: toggles ignored, pend_o[1] stays 0; pending set before masking still delivered.
- rst_i during OFFER -> all outputs 0 next cycle, no event delivered afterward.
